// File: rtl/mem_pkg.sv
// Shared definitions for the MEM pipeline stage: funct3 access codes, FSM
// encoding, the held control bundle and the lane-offset helper.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    IDLE = 1'b0,
    BUS  = 1'b1
  } mem_state_t;

  typedef struct packed {
    logic [4:0] rd;
    logic       reg_write;
    logic       mem_to_reg;
    logic       jal;
    logic       we;
    logic [2:0] funct3;
  } mem_ctrl_t;

  // Byte offset actually used for lanes: halfwords snap to even, words to 0.
  function automatic logic [1:0] lane_offset(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b00:   return a;
      2'b01:   return {a[1], 1'b0};
      default: return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// Load result alignment and extension: shifts the addressed lane down and
// sign- or zero-extends it according to funct3.
module load_extend
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [2:0]  funct3,
  input  logic [1:0]  a,
  output logic [31:0] ext
);

  logic [31:0]        byte_sh;
  logic [31:0]        half_sh;
  logic signed [7:0]  byte_s;
  logic signed [15:0] half_s;

  always_comb begin
    byte_sh = rdata >> {a, 3'b000};
    half_sh = rdata >> {a[1], 4'b0000};
    byte_s  = byte_sh[7:0];
    half_s  = half_sh[15:0];
    case (funct3)
      F3_B:    ext = {{24{byte_s[7]}}, byte_s};
      F3_H:    ext = {{16{half_s[15]}}, half_s};
      F3_BU:   ext = {24'h0, byte_sh[7:0]};
      F3_HU:   ext = {16'h0, half_sh[15:0]};
      default: ext = rdata;
    endcase
  end

endmodule

// File: rtl/memory_stage.sv
// RV32I MEM stage: valid/ready data-memory access, lane steering, load
// extension and the MEM/WB register. Optional macro: MEM_MISALIGN_TRAP_EN.
module memory_stage
  import mem_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            Valid_E,
  input  logic [4:0]      RD_E,
  input  logic            RegWriteEn_E,
  input  logic            MemtoReg_E,
  input  logic            JAL_E,
  input  logic            MemRead_E,
  input  logic            MemWrite_E,
  input  logic [2:0]      Funct3_E,
  input  logic [XLEN-1:0] ALU_ResultE,
  input  logic [XLEN-1:0] WriteDataE,
  input  logic [XLEN-1:0] PCPlus4E,
  output logic            Stall_M,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [3:0]      dmem_be,
  input  logic            dmem_ready,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic [4:0]      RD_M,
  output logic            RegWriteEn_M,
  output logic            MemtoReg_M,
  output logic            JAL_M,
  output logic [XLEN-1:0] PCPlus4W,
  output logic [XLEN-1:0] ALU_ResultW,
  output logic [XLEN-1:0] ReadDataW,
  output logic            Misalign_M
);

  mem_state_t      state_q, state_d;
  mem_ctrl_t       ctrl_p1;
  logic [XLEN-1:0] addr_p1, wd_p1, pc4_p1;
  logic [1:0]      off_p1;
  logic [XLEN-1:0] load_data_p1;
  logic            mem_op_e, misalign_e, accept_mem_e;

  assign mem_op_e = Valid_E & (MemRead_E | MemWrite_E);

`ifdef MEM_MISALIGN_TRAP_EN
  assign misalign_e = mem_op_e &
                      (lane_offset(Funct3_E, ALU_ResultE[1:0]) != ALU_ResultE[1:0]);
`else
  assign misalign_e = 1'b0;
`endif

  assign accept_mem_e = mem_op_e & ~misalign_e;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept_mem_e) state_d = BUS;
      BUS:     if (dmem_ready)   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign Stall_M = ~rst & (((state_q == IDLE) & accept_mem_e) |
                           ((state_q == BUS) & ~dmem_ready));

  // Stage p1: holding registers, loaded once per accepted memory access
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_p1 <= '0;
      addr_p1 <= '0;
      wd_p1   <= '0;
      pc4_p1  <= '0;
    end else if (state_q == IDLE && accept_mem_e) begin
      ctrl_p1 <= '{rd: RD_E, reg_write: RegWriteEn_E, mem_to_reg: MemtoReg_E,
                   jal: JAL_E, we: MemWrite_E, funct3: Funct3_E};
      addr_p1 <= ALU_ResultE;
      wd_p1   <= WriteDataE;
      pc4_p1  <= PCPlus4E;
    end
  end

  assign off_p1 = lane_offset(ctrl_p1.funct3, addr_p1[1:0]);

  always_comb begin
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    dmem_addr  = '0;
    dmem_wdata = '0;
    dmem_be    = 4'b0000;
    if (state_q == BUS) begin
      dmem_req  = 1'b1;
      dmem_we   = ctrl_p1.we;
      dmem_addr = {addr_p1[XLEN-1:2], 2'b00};
      case (ctrl_p1.funct3[1:0])
        2'b00: begin
          dmem_be    = 4'b0001 << off_p1;
          dmem_wdata = {4{wd_p1[7:0]}};
        end
        2'b01: begin
          dmem_be    = 4'b0011 << off_p1;
          dmem_wdata = {2{wd_p1[15:0]}};
        end
        default: begin
          dmem_be    = 4'b1111;
          dmem_wdata = wd_p1;
        end
      endcase
    end
  end

  load_extend u_load_extend (
    .rdata  (dmem_rdata),
    .funct3 (ctrl_p1.funct3),
    .a      (off_p1),
    .ext    (load_data_p1)
  );

  // Stage p2: MEM/WB register; anything not retiring this cycle is a bubble
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      RD_M         <= '0;
      RegWriteEn_M <= 1'b0;
      MemtoReg_M   <= 1'b0;
      JAL_M        <= 1'b0;
      PCPlus4W     <= '0;
      ALU_ResultW  <= '0;
      ReadDataW    <= '0;
      Misalign_M   <= 1'b0;
    end else begin
      RD_M         <= '0;
      RegWriteEn_M <= 1'b0;
      MemtoReg_M   <= 1'b0;
      JAL_M        <= 1'b0;
      PCPlus4W     <= '0;
      ALU_ResultW  <= '0;
      ReadDataW    <= '0;
      Misalign_M   <= 1'b0;
      if (state_q == IDLE) begin
        if (Valid_E && !mem_op_e) begin
          RD_M         <= RD_E;
          RegWriteEn_M <= RegWriteEn_E;
          MemtoReg_M   <= MemtoReg_E;
          JAL_M        <= JAL_E;
          PCPlus4W     <= PCPlus4E;
          ALU_ResultW  <= ALU_ResultE;
        end else if (misalign_e) begin
          Misalign_M   <= 1'b1;
        end
      end else if (dmem_ready) begin
        RD_M         <= ctrl_p1.rd;
        RegWriteEn_M <= ctrl_p1.reg_write;
        MemtoReg_M   <= ctrl_p1.mem_to_reg;
        JAL_M        <= ctrl_p1.jal;
        PCPlus4W     <= pc4_p1;
        ALU_ResultW  <= addr_p1;
        ReadDataW    <= ctrl_p1.we ? '0 : load_data_p1;
      end
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: a transaction-level model predicts
// bus and MEM/WB outputs each cycle; literal pins anchor the model.
module tb_memory_stage;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        Valid_E, RegWriteEn_E, MemtoReg_E, JAL_E, MemRead_E, MemWrite_E;
  logic [4:0]  RD_E;
  logic [2:0]  Funct3_E;
  logic [31:0] ALU_ResultE, WriteDataE, PCPlus4E;
  logic        Stall_M, dmem_req, dmem_we, dmem_ready;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic [4:0]  RD_M;
  logic        RegWriteEn_M, MemtoReg_M, JAL_M, Misalign_M;
  logic [31:0] PCPlus4W, ALU_ResultW, ReadDataW;

  memory_stage #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .Valid_E(Valid_E), .RD_E(RD_E),
    .RegWriteEn_E(RegWriteEn_E), .MemtoReg_E(MemtoReg_E), .JAL_E(JAL_E),
    .MemRead_E(MemRead_E), .MemWrite_E(MemWrite_E), .Funct3_E(Funct3_E),
    .ALU_ResultE(ALU_ResultE), .WriteDataE(WriteDataE), .PCPlus4E(PCPlus4E),
    .Stall_M(Stall_M), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
    .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata), .RD_M(RD_M),
    .RegWriteEn_M(RegWriteEn_M), .MemtoReg_M(MemtoReg_M), .JAL_M(JAL_M),
    .PCPlus4W(PCPlus4W), .ALU_ResultW(ALU_ResultW), .ReadDataW(ReadDataW),
    .Misalign_M(Misalign_M)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic        rw, m2r, jal, ld, st;
    logic [2:0]  f3;
    logic [31:0] addr, wd, pc4;
  } instr_t;

  typedef struct packed {
    logic [4:0]  rd;
    logic        rw, m2r, jal;
    logic [31:0] pc4, alu, rdata;
    logic        mis;
  } wb_t;

  typedef struct {
    int          sel;
    logic [31:0] exp;
  } pin_t;

  localparam int P_RDATA = 0, P_RD = 1, P_ALU = 2, P_M2R = 3, P_RW = 4, P_MIS = 5,
                 P_LBE = 6, P_LADDR = 7, P_LWDATA = 8, P_LWE = 9, P_STALL = 10,
                 P_REQ = 11, P_BE = 12, P_ADDR = 13, P_WDATA = 14, P_PC4 = 15;
  string pin_name [16] = '{"ReadDataW", "RD_M", "ALU_ResultW", "MemtoReg_M",
                           "RegWriteEn_M", "Misalign_M", "bus_be", "bus_addr",
                           "bus_wdata", "bus_we", "Stall_M_lit", "dmem_req_lit",
                           "dmem_be_lit", "dmem_addr_lit", "dmem_wdata_lit",
                           "PCPlus4W"};

  int          checks = 0, errors = 0;
  logic        chk_en = 1'b0;
  logic        exp_stall, exp_req, exp_we;
  logic [31:0] exp_addr, exp_wdata;
  logic [3:0]  exp_be;
  wb_t         exp_wb, exp_wb_next;
  pin_t        pins [64];
  int          wp = 0, rp = 0;
  logic        last_we;
  logic [3:0]  last_be;
  logic [31:0] last_addr, last_wdata;

  function automatic int size_of(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      default:        return 4;
    endcase
  endfunction

  // Start of the naturally aligned container holding the access.
  function automatic int offset_of(input logic [2:0] f3, input logic [31:0] addr);
    int a;
    a = int'(addr % 32'd4);
    return a - (a % size_of(f3));
  endfunction

  function automatic logic is_trap(input instr_t i);
`ifdef MEM_MISALIGN_TRAP_EN
    return (i.ld || i.st) && (offset_of(i.f3, i.addr) != int'(i.addr % 32'd4));
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] addr);
    int s;
    s = size_of(f3);
    return 4'(((1 << s) - 1) << offset_of(f3, addr));
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] r;
    int s;
    s = size_of(f3);
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % s) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] word);
    longint v;
    int     s;
    s = size_of(f3);
    if (s == 4) return word;
    v = longint'({32'h0, word}) >> (8 * offset_of(f3, addr));
    v = v % (64'sd1 << (8 * s));
    if (!f3[2] && v >= (64'sd1 << (8 * s - 1))) v = v - (64'sd1 << (8 * s));
    return v[31:0];
  endfunction

  function automatic wb_t model_wb(input instr_t i, input logic [31:0] word);
    wb_t w;
    w.rd    = i.rd;
    w.rw    = i.rw;
    w.m2r   = i.m2r;
    w.jal   = i.jal;
    w.pc4   = i.pc4;
    w.alu   = i.addr;
    w.rdata = i.ld ? model_load(i.f3, i.addr, word) : 32'h0;
    w.mis   = 1'b0;
    return w;
  endfunction

  function automatic instr_t mk(input logic [4:0] rd, input logic rw, input logic m2r,
                                input logic jal, input logic ld, input logic st,
                                input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wd, input logic [31:0] pc4);
    instr_t i;
    i.rd = rd; i.rw = rw; i.m2r = m2r; i.jal = jal; i.ld = ld; i.st = st;
    i.f3 = f3; i.addr = addr; i.wd = wd; i.pc4 = pc4;
    return i;
  endfunction

  function automatic logic [31:0] pin_actual(input int sel);
    case (sel)
      P_RDATA:  return ReadDataW;
      P_RD:     return 32'(RD_M);
      P_ALU:    return ALU_ResultW;
      P_M2R:    return 32'(MemtoReg_M);
      P_RW:     return 32'(RegWriteEn_M);
      P_MIS:    return 32'(Misalign_M);
      P_LBE:    return 32'(last_be);
      P_LADDR:  return last_addr;
      P_LWDATA: return last_wdata;
      P_LWE:    return 32'(last_we);
      P_STALL:  return 32'(Stall_M);
      P_REQ:    return 32'(dmem_req);
      P_BE:     return 32'(dmem_be);
      P_ADDR:   return dmem_addr;
      P_WDATA:  return dmem_wdata;
      P_PC4:    return PCPlus4W;
      default:  return 32'h0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("Stall_M", 32'(Stall_M), 32'(exp_stall));
      chk("dmem_req", 32'(dmem_req), 32'(exp_req));
      if (exp_req) begin
        chk("dmem_we", 32'(dmem_we), 32'(exp_we));
        chk("dmem_addr", dmem_addr, exp_addr);
        chk("dmem_be", 32'(dmem_be), 32'(exp_be));
        chk("dmem_wdata", dmem_wdata, exp_wdata);
      end
      chk("RD_M", 32'(RD_M), 32'(exp_wb.rd));
      chk("RegWriteEn_M", 32'(RegWriteEn_M), 32'(exp_wb.rw));
      chk("MemtoReg_M", 32'(MemtoReg_M), 32'(exp_wb.m2r));
      chk("JAL_M", 32'(JAL_M), 32'(exp_wb.jal));
      chk("PCPlus4W", PCPlus4W, exp_wb.pc4);
      chk("ALU_ResultW", ALU_ResultW, exp_wb.alu);
      chk("ReadDataW", ReadDataW, exp_wb.rdata);
      chk("Misalign_M", 32'(Misalign_M), 32'(exp_wb.mis));
    end
    while (rp != wp) begin
      chk(pin_name[pins[rp % 64].sel], pin_actual(pins[rp % 64].sel), pins[rp % 64].exp);
      rp++;
    end
    if (dmem_req) begin
      last_we    = dmem_we;
      last_be    = dmem_be;
      last_addr  = dmem_addr;
      last_wdata = dmem_wdata;
    end
  end

  task automatic pin(input int sel, input logic [31:0] e);
    pins[wp % 64] = '{sel: sel, exp: e};
    wp++;
  endtask

  task automatic step();
    @(posedge clk);
    exp_wb = exp_wb_next;
    #1;
  endtask

  task automatic drive(input instr_t i, input logic v);
    Valid_E      = v;
    RD_E         = i.rd;
    RegWriteEn_E = i.rw;
    MemtoReg_E   = i.m2r;
    JAL_E        = i.jal;
    MemRead_E    = i.ld;
    MemWrite_E   = i.st;
    Funct3_E     = i.f3;
    ALU_ResultE  = i.addr;
    WriteDataE   = i.wd;
    PCPlus4E     = i.pc4;
  endtask

  task automatic drive_junk();
    Valid_E      = 1'b1;
    RD_E         = 5'($urandom);
    RegWriteEn_E = 1'($urandom);
    MemtoReg_E   = 1'($urandom);
    JAL_E        = 1'($urandom);
    MemRead_E    = 1'b1;
    MemWrite_E   = 1'b0;
    Funct3_E     = 3'($urandom);
    ALU_ResultE  = $urandom;
    WriteDataE   = $urandom;
    PCPlus4E     = $urandom;
  endtask

  task automatic bus_cycle(input instr_t i, input logic rdy, input logic [31:0] word);
    drive_junk();
    dmem_ready  = rdy;
    dmem_rdata  = rdy ? word : $urandom;
    exp_req     = 1'b1;
    exp_we      = i.st;
    exp_addr    = i.addr - (i.addr % 32'd4);
    exp_be      = model_be(i.f3, i.addr);
    exp_wdata   = model_wdata(i.f3, i.wd);
    exp_stall   = ~rdy;
    exp_wb_next = rdy ? model_wb(i, word) : '0;
    step();
  endtask

  // One instruction from acceptance to retirement; n = BUS cycles to ready.
  task automatic run_op(input instr_t i, input int n, input logic [31:0] word,
                        input logic idle_rdy);
    drive(i, 1'b1);
    exp_req = 1'b0;
    if ((i.ld || i.st) && !is_trap(i)) begin
      dmem_ready  = 1'b0;
      exp_stall   = 1'b1;
      exp_wb_next = '0;
      step();
      for (int k = 1; k <= n; k++) bus_cycle(i, k == n, word);
    end else begin
      dmem_ready  = idle_rdy;
      dmem_rdata  = $urandom;
      exp_stall   = 1'b0;
      exp_wb_next = is_trap(i) ? wb_t'(1) : model_wb(i, 32'h0);
      step();
    end
    dmem_ready = 1'b0;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
    exp_req   = 1'b0;
    exp_stall = 1'b0;
  endtask

  task automatic idle_cycle(input logic rdy);
    drive_junk();
    Valid_E     = 1'b0;
    dmem_ready  = rdy;
    exp_stall   = 1'b0;
    exp_req     = 1'b0;
    exp_wb_next = '0;
    step();
    dmem_ready  = 1'b0;
  endtask

  initial begin
    instr_t i;
    rst = 1'b1;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
    dmem_ready  = 1'b0;
    dmem_rdata  = 32'h0;
    exp_stall   = 1'b0;
    exp_req     = 1'b0;
    exp_we      = 1'b0;
    exp_addr    = 32'h0;
    exp_be      = 4'h0;
    exp_wdata   = 32'h0;
    exp_wb      = '0;
    exp_wb_next = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    pin(P_REQ, 0); pin(P_BE, 0); pin(P_ADDR, 0); pin(P_WDATA, 0); pin(P_STALL, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // ALU op with a stray dmem_ready that must be ignored in IDLE
    run_op(mk(5'd5, 1, 0, 0, 0, 0, 3'b000, 32'h1234, 32'h0, 32'h104), 0, 32'h0, 1'b1);
    pin(P_RD, 5); pin(P_ALU, 32'h1234); pin(P_PC4, 32'h104);
    run_op(mk(5'd1, 1, 0, 1, 0, 0, 3'b000, 32'h999, 32'h0, 32'h208), 0, 32'h0, 1'b0);
    idle_cycle(1'b1);

    run_op(mk(5'd7, 1, 1, 0, 1, 0, F3_B, 32'h1003, 32'h0, 32'h300), 2, 32'h80FF_0000, 1'b0);
    pin(P_RDATA, 32'hFFFF_FF80); pin(P_M2R, 1); pin(P_LADDR, 32'h1000); pin(P_LBE, 4'b1000);

    run_op(mk(5'd8, 1, 1, 0, 1, 0, F3_HU, 32'h2002, 32'h0, 32'h304), 1, 32'h8001_0000, 1'b0);
    pin(P_RDATA, 32'h0000_8001);

    run_op(mk(5'd0, 0, 0, 0, 0, 1, F3_H, 32'h3002, 32'hABCD_1234, 32'h308), 3, 32'h0, 1'b0);
    pin(P_LBE, 4'b1100); pin(P_LWDATA, 32'h1234_1234); pin(P_LWE, 1); pin(P_RW, 0);
    pin(P_RDATA, 0);

    i = mk(5'd9, 1, 1, 0, 1, 0, F3_W, 32'h4001, 32'h0, 32'h30C);
`ifdef MEM_MISALIGN_TRAP_EN
    run_op(i, 2, 32'hDEAD_BEEF, 1'b0);
    pin(P_MIS, 1); pin(P_RW, 0); pin(P_RD, 0);
`else
    run_op(i, 2, 32'hDEAD_BEEF, 1'b0);
    pin(P_LADDR, 32'h4000); pin(P_RDATA, 32'hDEAD_BEEF); pin(P_MIS, 0);
`endif
    idle_cycle(1'b0);

    run_op(mk(5'd10, 1, 1, 0, 1, 0, F3_H, 32'h5002, 32'h0, 32'h310), 2, 32'h8001_7FFF, 1'b0);
    pin(P_RDATA, 32'hFFFF_8001);
    run_op(mk(5'd11, 1, 1, 0, 1, 0, F3_BU, 32'h6002, 32'h0, 32'h314), 1, 32'h00AB_0000, 1'b0);
    pin(P_RDATA, 32'h0000_00AB);
    run_op(mk(5'd0, 0, 0, 0, 0, 1, F3_B, 32'h7001, 32'h0000_0055, 32'h318), 1, 32'h0, 1'b0);
    pin(P_LBE, 4'b0010); pin(P_LWDATA, 32'h5555_5555);
    run_op(mk(5'd12, 1, 1, 0, 1, 0, F3_H, 32'h5001, 32'h0, 32'h31C), 2, 32'hC3A5_5A3C, 1'b0);
    run_op(mk(5'd13, 1, 1, 0, 1, 0, 3'b011, 32'h9000, 32'h0, 32'h320), 1, 32'h1357_9BDF, 1'b0);
    run_op(mk(5'd14, 1, 1, 0, 1, 0, F3_B, 32'h8002, 32'h0, 32'h324), 1, 32'h0080_0000, 1'b0);
    pin(P_RDATA, 32'hFFFF_FF80);

    // Reset asserted in the second BUS cycle of a long load
    i = mk(5'd15, 1, 1, 0, 1, 0, F3_B, 32'h8000, 32'h0, 32'h400);
    drive(i, 1'b1);
    exp_stall   = 1'b1;
    exp_wb_next = '0;
    step();
    bus_cycle(i, 1'b0, 32'h0);
    rst = 1'b1;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
    exp_req     = 1'b0;
    exp_stall   = 1'b0;
    exp_wb      = '0;
    exp_wb_next = '0;
    pin(P_REQ, 0); pin(P_BE, 0); pin(P_ADDR, 0); pin(P_STALL, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle_cycle(1'b0);
    run_op(mk(5'd21, 1, 0, 0, 0, 0, 3'b000, 32'h0000_0BAD, 32'h0, 32'h500), 0, 32'h0, 1'b0);
    pin(P_RD, 21); pin(P_ALU, 32'h0000_0BAD);
    run_op(mk(5'd22, 1, 1, 0, 1, 0, F3_W, 32'hA000, 32'h0, 32'h504), 1, 32'h2468_ACE0, 1'b0);
    pin(P_RDATA, 32'h2468_ACE0);

    repeat (3) idle_cycle(1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/memory_stage.md
# memory_stage

Pipeline MEM stage between the execute stage and `writeback_stage`. It performs RV32I loads and stores over a valid/ready data-memory bus and handles byte and halfword lane steering and load extension. It stalls the upstream pipeline while an access is outstanding and registers the MEM/WB pipeline values consumed by `writeback_stage`.

## Interface
Parameters:
- `XLEN`, 32: data and address width; only 32 is supported.

Ports:
- `clk` input 1: clock, rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `Valid_E` input 1: an execute-stage instruction is present.
- `RD_E` input 5: destination register.
- `RegWriteEn_E`, `MemtoReg_E`, `JAL_E` input 1 each: write-back controls.
- `MemRead_E`, `MemWrite_E` input 1 each: load or store; never both set.
- `Funct3_E` input 3: access size and sign.
- `ALU_ResultE` input 32: effective address or ALU result.
- `WriteDataE` input 32: store data (rs2).
- `PCPlus4E` input 32: link value.
- `Stall_M` output 1: the execute stage and earlier stages must hold.
- `dmem_req` output 1: bus request.
- `dmem_we` output 1: 1 = write.
- `dmem_addr` output 32: word-aligned address.
- `dmem_wdata` output 32: lane-replicated store data.
- `dmem_be` output 4: byte enables.
- `dmem_ready` input 1: bus completes the access this cycle.
- `dmem_rdata` input 32: read word, valid when `dmem_ready`=1.
- `RD_M` output 5, registered.
- `RegWriteEn_M`, `MemtoReg_M`, `JAL_M` output 1 each, registered.
- `PCPlus4W`, `ALU_ResultW`, `ReadDataW` output 32 each, registered.
- `Misalign_M` output 1, registered: the access just retired was misaligned.

## Operation
- FSM states:
  - IDLE: accept from execute.
  - BUS: request outstanding.
- IDLE, non-memory instruction (or `Valid_E`=0): the MEM/WB register loads the inputs on the next edge. `Valid_E`=0 loads a bubble. Stay in IDLE.
- IDLE, memory instruction:
  - Capture address, data, size and controls into internal holding registers.
  - Go to BUS.
  - `Stall_M`=1 combinationally this cycle.
  - The MEM/WB register loads a bubble.
- BUS:
  - `dmem_req`=1 and all bus outputs are driven from the holding registers and held stable until `dmem_ready`.
  - `Stall_M` = !`dmem_ready`.
  - While `dmem_ready`=0, the MEM/WB register loads a bubble.
  - On `dmem_ready`=1, the MEM/WB register loads the held instruction, with `ReadDataW` = the extended load result, or 0 for stores. Return to IDLE.
- Bubble: `RegWriteEn_M`=0, `RD_M`=0, all other MEM/WB outputs 0.
- Lane rules, with `a` = address[1:0]:
  - `dmem_addr` = {addr[31:2], 2'b00}.
  - Byte (000/100): `dmem_be`=4'b0001<<`a`, wdata={4{wd[7:0]}}.
  - Half (001/101): `dmem_be`=4'b0011<<{a[1],0}, wdata={2{wd[15:0]}}.
  - Word (010): `dmem_be`=4'b1111.
  - Any other `Funct3_E` code is treated as word.
  - Loads drive `dmem_be` the same way as stores.
- Load extend: shift `dmem_rdata` right by 8*`a` (halfword: 16*a[1]). Sign-extend for 000/001, zero-extend for 100/101, pass the full word for 010.

## Timing
- Reset: every output 0, FSM in IDLE, holding registers 0. `dmem_req` falls immediately on `rst` assertion, even mid-access. The bus must tolerate an abandoned request.
- Non-memory latency: 1 cycle, no stall.
- Memory latency: the IDLE cycle plus N BUS cycles, where N ≥ 1 and `dmem_ready` rises in the Nth BUS cycle. The result appears in the MEM/WB register on the edge ending that cycle.
- Stall cycles: N for a memory op. `Stall_M` and `dmem_ready` are never both high in IDLE.
- `dmem_ready` in the first BUS cycle gives the minimum memory latency of 2 cycles.
- A new execute instruction is accepted in IDLE on the cycle after the BUS completion; there are no back-to-back BUS states.
- `dmem_ready` while in IDLE is ignored.

## Configuration
- `MEM_MISALIGN_TRAP_EN` defined:
  - A halfword at odd `a`, or a word with `a`≠0, issues no bus request and takes no stall.
  - The instruction retires in 1 cycle as a bubble with `Misalign_M`=1.
  - Otherwise `Misalign_M`=0.
- `MEM_MISALIGN_TRAP_EN` undefined: the low address bits are forced to alignment (half: a[0]=0; word: a=0) for lanes and extension, and `Misalign_M` is tied 0.

## Structure
- Package `mem_pkg`:
  - Funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - FSM state encoding (IDLE, BUS).
  - A `mem_ctrl_t`-style bundle of the held control bits.
- Sub-module `load_extend`: combinational; inputs rdata, funct3 and `a`; output the extended 32-bit value.
- Byte-enable and write-data replication stay inline.

## Test plan
- ALU op: RD_E=5, ALU_ResultE=0x1234, RegWriteEn_E=1 → next edge RD_M=5, ALU_ResultW=0x1234, `Stall_M` never 1.
- LB at 0x1003, `dmem_ready` after 2 BUS cycles, rdata=0x80FF_0000 → `dmem_addr`=0x1000, `dmem_be`=4'b1000, `Stall_M` high 2 cycles then low, ReadDataW=0xFFFF_FF80, MemtoReg_M=1.
- LHU at 0x2002, rdata=0x8001_0000, ready in the first BUS cycle → ReadDataW=0x0000_8001, 2-cycle latency.
- SH at 0x3002 with wd=0xABCD_1234 → `dmem_we`=1, `dmem_be`=4'b1100, `dmem_wdata`=0x1234_1234, bus outputs stable until ready, RegWriteEn_M=0.
- LW at 0x4001: with `MEM_MISALIGN_TRAP_EN`, expect no `dmem_req`, `Misalign_M`=1 for 1 cycle and a bubble. Without the macro, expect `dmem_addr`=0x4000 and a full-word result.
- `rst` pulsed in the second BUS cycle → `dmem_req` drops the same cycle, all outputs 0, FSM in IDLE. The next ALU op completes normally.
